// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: MSB-first serial receiver that aligns on comma bytes and emits one byte per 8 clk8f edges
module serial_to_parallel_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);
  typedef enum logic [1:0] {HUNT, LOCK, ACTIVE} state_e;
  localparam logic [3:0] SYNC = 4'(SYNC_COUNT);
  state_e     state_q, state_d;
  logic [6:0] shift_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d, active_q, active_d;
  logic [7:0] b;
  logic       is_comma, boundary;
  assign b        = {shift_q, data_in};
  assign is_comma = b == COMMA;
  assign boundary = state_q != HUNT && bit_cnt_q == 3'd7;
  // state, counters, shifter and registered outputs; reset clears everything at once
  always_ff @(posedge clk8f or negedge reset)
    if (!reset) begin
      state_q     <= HUNT;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= b[6:0];
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
    end
  // alignment search: any comma locks in HUNT, LOCK then demands commas on every boundary
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + 3'd1;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      HUNT:
        if (is_comma) begin
          state_d     = LOCK;
          bit_cnt_d   = '0;
          comma_cnt_d = 4'd1;
        end
      LOCK:
        if (boundary && !is_comma) begin
          state_d     = HUNT;
          comma_cnt_d = '0;
        end else if (boundary) begin
          comma_cnt_d = comma_cnt_q + 4'd1;
          state_d     = comma_cnt_q + 4'd1 == SYNC ? ACTIVE : LOCK;
        end
      default: ;
    endcase
  end
  // byte output only updates on ACTIVE boundaries; commas there become idle slots
  always_comb begin
    data_d   = state_q == ACTIVE && boundary ? b : data_q;
    valid_d  = state_q == ACTIVE && boundary ? !is_comma : valid_q;
    active_d = state_d == ACTIVE;
  end
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: scoreboard bench for the comma-aligned serial receiver
module tb_serial_to_parallel_rx;
  logic       clk8f = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, active;
  int         checks = 0, errors = 0;
  logic [8:0] sb[$];
  serial_to_parallel_rx dut (
    .clk8f(clk8f), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );
  always #5 clk8f = ~clk8f;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bit(input logic v);
    @(negedge clk8f) data_in = v;
  endtask
  // out: byte should appear on data_out at its last edge; act: expected active afterwards
  task automatic send_byte(input logic [7:0] v, input bit out, input bit act);
    logic [8:0] e;
    if (out) sb.push_back({v, v != 8'hBC});
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    @(posedge clk8f) #1;
    check("active", active, act);
    if (out) begin
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        check("data", data_out, e[8:1]);
        check("valid", valid_out, e[0]);
      end
    end else if (!act) begin
      check("data_idle", data_out, 8'h00);
      check("valid_idle", valid_out, 0);
    end
  endtask
  task automatic pulse_reset();
    @(negedge clk8f) reset = 1'b0;
    #1;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid_out, 0);
    check("rst_active", active, 0);
    @(negedge clk8f) reset = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk8f);
    #1;
    check("init_data", data_out, 8'h00);
    check("init_valid", valid_out, 0);
    check("init_active", active, 0);
    @(negedge clk8f) reset = 1'b1;
    for (int i = 0; i < 4; i++) send_byte(8'hBC, 0, i == 3);
    send_byte(8'hAA, 1, 1);
    send_byte(8'hBC, 1, 1);
    send_byte(8'h3C, 1, 1);
    send_byte(8'hC3, 1, 1);
    pulse_reset();
    for (int i = 0; i < 3; i++) send_byte(8'hBC, 0, 0);
    send_byte(8'h55, 0, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC, 0, i == 3);
    send_byte(8'h12, 1, 1);
    pulse_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'hBC, 0, i == 3);
    send_byte(8'h0F, 1, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(posedge clk8f) #2 reset = 1'b0;
    #1;
    check("mid_data", data_out, 8'h00);
    check("mid_valid", valid_out, 0);
    check("mid_active", active, 0);
    @(negedge clk8f) reset = 1'b1;
    send_byte(8'h77, 0, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC, 0, i == 3);
    send_byte(8'h77, 1, 1);
    send_byte(8'hBC, 1, 1);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
